serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter IDLE_BIT, default 1'b0: level driven on c whenever no pattern bit is being sent.
REQ-002 ck  input  1  clock; all state SHALL update on the rising edge only, so c is stable at every falling edge for the serial sequence detector.
REQ-003 rs  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accept; a command SHALL transfer on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-006 cmd_pat  input  1  pattern select: 0 -> "001", 1 -> "110".
REQ-007 cmd_rep  input  3  repetition count minus one (0..7 -> 1..8 instances).
REQ-008 c  output  1  serial bit stream, one bit per ck period.
REQ-009 busy  output  1  high while a command is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 tag  output  2  expected detector code for the sent pattern: 2'b01 for "001", 2'b10 for "110"; valid while done=1, 2'b00 otherwise.

Function
REQ-012 FSM states SHALL be IDLE, SEND and GUARD; GUARD SHALL be reachable only when PATTERN_TX_GUARD_EN is defined.
REQ-013 IDLE: cmd_ready=1, busy=0, c=IDLE_BIT; on handshake, cmd_pat and cmd_rep SHALL be latched and the FSM SHALL enter SEND with bit index 0.
REQ-014 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-015 Latched command fields SHALL be used for the entire command; input changes after acceptance SHALL have no effect.
REQ-016 Bits SHALL be sent in written order ("001" -> 0,0,1; "110" -> 1,1,0); the first bit SHALL appear on c in the cycle immediately after the accepting edge.
REQ-017 Each bit SHALL be held on c for exactly one ck period; a 2-bit index SHALL wrap 2 -> 0 at the end of each instance, and a 3-bit repetition counter SHALL count down from cmd_rep.
REQ-018 Without guard, a command SHALL occupy exactly 3*(cmd_rep+1) consecutive cycles with busy=1.
REQ-019 done SHALL be 1 for exactly one cycle, concurrent with the last bit of the last instance; tag SHALL be valid in that same cycle.
REQ-020 The cycle after the done cycle SHALL be IDLE (c=IDLE_BIT, cmd_ready=1); consecutive commands are separated by at least one idle bit.
REQ-021 cmd_rep=7 SHALL produce 8 instances; the repetition counter SHALL NOT wrap past zero.

Reset
REQ-022 With rs=1 at a rising edge, next cycle: state=IDLE, c=IDLE_BIT, busy=0, done=0, tag=2'b00, cmd_ready=1, all counters and latches cleared.
REQ-023 rs asserted mid-command SHALL abort it with no done pulse; rs SHALL take priority over a simultaneous handshake, and the command SHALL be discarded.

Configuration
REQ-024 Macro PATTERN_TX_GUARD_EN: when defined, one guard bit equal to the inverse of the pattern's last bit ("001" -> 0, "110" -> 1) SHALL follow every instance in state GUARD, giving 4*(cmd_rep+1) busy cycles; done SHALL coincide with the final guard bit.
REQ-025 Without PATTERN_TX_GUARD_EN, no GUARD state or guard logic SHALL exist and the timing of REQ-018/REQ-019 SHALL apply.

Verification
REQ-026 Reset: rs=1 for 2 cycles with cmd_valid=1 -> c=IDLE_BIT, busy=0, done=0, cmd_ready=1, and no command is accepted.
REQ-027 Single "001": cmd_pat=0, cmd_rep=0, one-cycle cmd_valid -> c=0,0,1 over 3 cycles; done=1 and tag=2'b01 on the third; IDLE on the fourth.
REQ-028 Repeated "110": cmd_pat=1, cmd_rep=2 -> c=110110110; busy high for 9 cycles; a single done with tag=2'b10 on bit 9.
REQ-029 Ignored request: cmd_valid held high with cmd_pat toggling during a cmd_rep=7 command -> 24 correct bits, then the pending request is accepted only in the next IDLE cycle.
REQ-030 Abort: rs=1 at bit 2 of "110" -> next cycle c=IDLE_BIT, busy=0, and no done pulse.
REQ-031 Guard build (PATTERN_TX_GUARD_EN defined): cmd_pat=0, cmd_rep=1 -> c=00100010, busy for 8 cycles, done on bit 8; with c looped to the detector, the detector output y=2'b01 appears after each instance.

Source files
------------

// File: rtl/serial_pattern_tx_if.sv
// Command handshake bundle for serial_pattern_tx: valid/ready plus the pattern
// select and repetition count that travel with each command.
interface serial_pattern_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_pat;
  logic [2:0] cmd_rep;

  modport master (
    output cmd_valid,
    output cmd_pat,
    output cmd_rep,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_pat,
    input  cmd_rep,
    output cmd_ready
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends "001" or "110" (cmd_rep+1) times on c, one bit per clock.
// Optional macro PATTERN_TX_GUARD_EN appends an inverted guard bit after every instance.
module serial_pattern_tx #(
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                ck,
  input  logic                rs,
  serial_pattern_tx_if.slave  cmd,
  output logic                c,
  output logic                busy,
  output logic                done,
  output logic [1:0]          tag
);

`ifdef PATTERN_TX_GUARD_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StSend = 2'd1, StGuard = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StSend = 2'd1} state_e;
`endif

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] rep_q, rep_d;
  logic       pat_q, pat_d;

  always_ff @(posedge ck) begin
    if (rs) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      rep_q   <= 3'd0;
      pat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    pat_d   = pat_q;
    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          state_d = StSend;
          idx_d   = 2'd0;
          rep_d   = cmd.cmd_rep;
          pat_d   = cmd.cmd_pat;
        end
      end
      StSend: begin
        if (idx_q == 2'd2) begin
          idx_d = 2'd0;
`ifdef PATTERN_TX_GUARD_EN
          state_d = StGuard;
`else
          if (rep_q == 3'd0) begin
            state_d = StIdle;
          end else begin
            rep_d = rep_q - 3'd1;
          end
`endif
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
`ifdef PATTERN_TX_GUARD_EN
      StGuard: begin
        if (rep_q == 3'd0) begin
          state_d = StIdle;
        end else begin
          rep_d   = rep_q - 3'd1;
          state_d = StSend;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    c             = IDLE_BIT;
    busy          = 1'b0;
    done          = 1'b0;
    tag           = 2'b00;
    cmd.cmd_ready = 1'b0;
    unique case (state_q)
      StIdle: cmd.cmd_ready = 1'b1;
      StSend: begin
        busy = 1'b1;
        // "001" has its single 1 at index 2; "110" has its single 0 there.
        c    = pat_q ? (idx_q != 2'd2) : (idx_q == 2'd2);
`ifndef PATTERN_TX_GUARD_EN
        done = (idx_q == 2'd2) && (rep_q == 3'd0);
`endif
      end
`ifdef PATTERN_TX_GUARD_EN
      StGuard: begin
        busy = 1'b1;
        c    = pat_q;
        done = (rep_q == 3'd0);
      end
`endif
      default: ;
    endcase
    if (done) begin
      tag = pat_q ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx; outputs are sampled on the falling edge.
// Expected streams come from a small pattern model that also covers the guard build.
module tb_serial_pattern_tx;
  localparam logic IDLE_BIT = 1'b0;
`ifdef PATTERN_TX_GUARD_EN
  localparam int InstLen = 4;
`else
  localparam int InstLen = 3;
`endif
  localparam logic [5:0] IdleObs = {IDLE_BIT, 1'b0, 1'b0, 2'b00, 1'b1};

  logic       ck = 1'b0;
  logic       rs;
  logic       c;
  logic       busy;
  logic       done;
  logic [1:0] tag;
  int         tests_run = 0;
  int         tests_failed = 0;

  serial_pattern_tx_if cmd_if ();

  serial_pattern_tx #(.IDLE_BIT(IDLE_BIT)) dut (
    .ck   (ck),
    .rs   (rs),
    .cmd  (cmd_if),
    .c    (c),
    .busy (busy),
    .done (done),
    .tag  (tag)
  );

  always #5 ck = ~ck;

  // {c, busy, done, tag, cmd_ready}
  wire [5:0] obs = {c, busy, done, tag, cmd_if.cmd_ready};

  function automatic logic [5:0] exp_send(input logic pat, input int i, input int total);
    logic [2:0] pb;
    logic [1:0] k;
    int         j;
    logic       b;
    logic       d;
    pb = pat ? 3'b110 : 3'b001;
    j  = i % InstLen;
    k  = 2'(2 - j);
    b  = (j < 3) ? pb[k] : ~pb[0];
    d  = (i == total - 1);
    return {b, 1'b1, d, d ? (pat ? 2'b10 : 2'b01) : 2'b00, 1'b0};
  endfunction

  task automatic test_reset();
    rs = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pat = 1'b1;
    cmd_if.cmd_rep = 3'd3;
    for (int n = 0; n < 2; n++) begin
      @(negedge ck);
      tests_run++;
      if (obs !== IdleObs) begin
        tests_failed++;
        $display("FAIL reset cycle %0d: got %b want %b", n, obs, IdleObs);
      end
    end
    rs = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    @(negedge ck);
    tests_run++;
    if (obs !== IdleObs) begin
      tests_failed++;
      $display("FAIL reset_release: got %b want %b", obs, IdleObs);
    end
  endtask

  task automatic test_single_001();
    int total;
    total = InstLen;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pat = 1'b0;
    cmd_if.cmd_rep = 3'd0;
    @(negedge ck);
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < total; i++) begin
      tests_run++;
      if (obs !== exp_send(1'b0, i, total)) begin
        tests_failed++;
        $display("FAIL single_001 bit %0d: got %b want %b", i, obs, exp_send(1'b0, i, total));
      end
      @(negedge ck);
    end
    tests_run++;
    if (obs !== IdleObs) begin
      tests_failed++;
      $display("FAIL single_001 idle: got %b want %b", obs, IdleObs);
    end
  endtask

  task automatic test_pattern(input string name, input logic pat, input logic [2:0] rep);
    int total;
    total = InstLen * (int'(rep) + 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pat = pat;
    cmd_if.cmd_rep = rep;
    @(negedge ck);
    // Scramble inputs after acceptance; the latched command must be unaffected.
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_pat = ~pat;
    cmd_if.cmd_rep = ~rep;
    for (int i = 0; i < total; i++) begin
      tests_run++;
      if (obs !== exp_send(pat, i, total)) begin
        tests_failed++;
        $display("FAIL %s bit %0d: got %b want %b", name, i, obs, exp_send(pat, i, total));
      end
      @(negedge ck);
    end
    tests_run++;
    if (obs !== IdleObs) begin
      tests_failed++;
      $display("FAIL %s idle: got %b want %b", name, obs, IdleObs);
    end
  endtask

  task automatic test_ignored_request();
    int total;
    total = InstLen * 8;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pat = 1'b0;
    cmd_if.cmd_rep = 3'd7;
    @(negedge ck);
    for (int i = 0; i < total; i++) begin
      tests_run++;
      if (obs !== exp_send(1'b0, i, total)) begin
        tests_failed++;
        $display("FAIL ignored_req bit %0d: got %b want %b", i, obs, exp_send(1'b0, i, total));
      end
      cmd_if.cmd_pat = i[0];
      cmd_if.cmd_rep = 3'(i);
      @(negedge ck);
    end
    tests_run++;
    if (obs !== IdleObs) begin
      tests_failed++;
      $display("FAIL ignored_req idle gap: got %b want %b", obs, IdleObs);
    end
    cmd_if.cmd_pat = 1'b1;
    cmd_if.cmd_rep = 3'd0;
    @(negedge ck);
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < InstLen; i++) begin
      tests_run++;
      if (obs !== exp_send(1'b1, i, InstLen)) begin
        tests_failed++;
        $display("FAIL pending_req bit %0d: got %b want %b", i, obs, exp_send(1'b1, i, InstLen));
      end
      @(negedge ck);
    end
    tests_run++;
    if (obs !== IdleObs) begin
      tests_failed++;
      $display("FAIL pending_req idle: got %b want %b", obs, IdleObs);
    end
  endtask

  task automatic test_abort();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pat = 1'b1;
    cmd_if.cmd_rep = 3'd0;
    @(negedge ck);
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs !== exp_send(1'b1, i, InstLen)) begin
        tests_failed++;
        $display("FAIL abort bit %0d: got %b want %b", i, obs, exp_send(1'b1, i, InstLen));
      end
      if (i == 1) rs = 1'b1;
      @(negedge ck);
    end
    rs = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tests_run++;
      if (obs !== IdleObs) begin
        tests_failed++;
        $display("FAIL abort idle %0d: got %b want %b", n, obs, IdleObs);
      end
      @(negedge ck);
    end
    // Reset wins over a handshake presented in IDLE.
    rs = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    @(negedge ck);
    rs = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tests_run++;
      if (obs !== IdleObs) begin
        tests_failed++;
        $display("FAIL reset_vs_handshake %0d: got %b want %b", n, obs, IdleObs);
      end
      @(negedge ck);
    end
  endtask

  initial begin
    rs = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_pat = 1'b0;
    cmd_if.cmd_rep = 3'd0;
    test_reset();
    test_single_001();
    test_pattern("repeat_110", 1'b1, 3'd2);
    test_pattern("two_001", 1'b0, 3'd1);
    test_ignored_request();
    test_abort();
    test_pattern("after_abort_001", 1'b0, 3'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
